// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency single-ported RAM between IF and MEM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_LEN    = 32,
    parameter int DATA_LEN    = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_LEN-1:0] if_addr,
    output logic [DATA_LEN-1:0] if_rdata,
    output logic                if_ready,
    input  logic                mem_r_en,
    input  logic                mem_w_en,
    input  logic [ADDR_LEN-1:0] mem_addr,
    input  logic [DATA_LEN-1:0] mem_wdata,
    output logic [DATA_LEN-1:0] mem_rdata,
    output logic                mem_ready,
    output logic [ADDR_LEN-1:0] ram_addr,
    output logic [DATA_LEN-1:0] ram_wdata,
    output logic                ram_re,
    output logic                ram_we,
    input  logic [DATA_LEN-1:0] ram_rdata,
    output logic                if_stall,
    output logic                mem_stall
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] c_CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic       r_own_mem;
    logic       r_op_wr;
    logic       w_req_mem;

    assign w_req_mem = mem_r_en | mem_w_en;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_req_mem || if_req) w_next = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_own_mem <= 1'b0;
            r_op_wr   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    // MEM wins ties: it carries the older instruction
                    if (w_req_mem) begin
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                        r_own_mem <= 1'b1;
                        r_op_wr   <= mem_w_en;
                        r_cnt     <= c_CNT_INIT;
                    end else if (if_req) begin
                        ram_addr  <= if_addr;
                        r_own_mem <= 1'b0;
                        r_op_wr   <= 1'b0;
                        r_cnt     <= c_CNT_INIT;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!r_op_wr) begin
                        if (r_own_mem) mem_rdata <= ram_rdata;
                        else           if_rdata  <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Combinational outputs are forced low while reset is asserted
    assign ram_re    = rst & (r_state == S_ACCESS) & ~r_op_wr;
    assign ram_we    = rst & (r_state == S_ACCESS) &  r_op_wr;
    assign if_ready  = rst & (r_state == S_RESP)   & ~r_own_mem;
    assign mem_ready = rst & (r_state == S_RESP)   &  r_own_mem;
    assign if_stall  = rst & if_req    & ~if_ready;
    assign mem_stall = rst & w_req_mem & ~mem_ready;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter (latency 2/1/15).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_r_en, mem_w_en;
    logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;

    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
    logic        if_ready, mem_ready, ram_re, ram_we, if_stall, mem_stall;

    logic [31:0] a_if_rdata, a_mem_rdata, a_ram_addr, a_ram_wdata;
    logic        a_if_ready, a_mem_ready, a_ram_re, a_ram_we, a_if_stall, a_mem_stall;

    logic [31:0] b_if_rdata, b_mem_rdata, b_ram_addr, b_ram_wdata;
    logic        b_if_ready, b_mem_ready, b_ram_re, b_ram_we, b_if_stall, b_mem_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .MEM_LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .if_stall(if_stall), .mem_stall(mem_stall)
    );

    mem_port_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .MEM_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(a_mem_rdata), .mem_ready(a_mem_ready),
        .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_re(a_ram_re), .ram_we(a_ram_we),
        .ram_rdata(ram_rdata), .if_stall(a_if_stall), .mem_stall(a_mem_stall)
    );

    mem_port_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .MEM_LATENCY(15)) u_lat15 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_re(b_ram_re), .ram_we(b_ram_we),
        .ram_rdata(ram_rdata), .if_stall(b_if_stall), .mem_stall(b_mem_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks run 1ns later, far from the rising edge
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; ram_rdata = '0;

        // ---------------- reset ----------------
        cyc(); #1;
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        cyc(); if_req = 1'b1; mem_w_en = 1'b1; #1;
        chk("rst_if_stall", if_stall, 0);
        chk("rst_mem_stall", mem_stall, 0);
        chk("rst_ram_we_req", ram_we, 0);
        cyc(); rst = 1'b1; if_req = 1'b0; mem_w_en = 1'b0; #1;
        chk("idle_ram_re", ram_re, 0);

        // ---------------- IF read, address changed mid-access ----------------
        cyc(); if_req = 1'b1; if_addr = 32'h10; ram_rdata = 32'hDEADBEEF; #1;
        chk("if_c0_stall", if_stall, 1);
        chk("if_c0_re", ram_re, 0);
        cyc(); if_addr = 32'h20; #1;
        chk("if_c1_re", ram_re, 1);
        chk("if_c1_addr", ram_addr, 32'h10);
        chk("if_c1_stall", if_stall, 1);
        chk("if_c1_ready", if_ready, 0);
        cyc(); #1;
        chk("if_c2_re", ram_re, 1);
        chk("if_c2_addr", ram_addr, 32'h10);
        chk("if_c2_stall", if_stall, 1);
        chk("if_c2_ready", if_ready, 0);
        cyc(); #1;
        chk("if_c3_ready", if_ready, 1);
        chk("if_c3_rdata", if_rdata, 32'hDEADBEEF);
        chk("if_c3_stall", if_stall, 0);
        chk("if_c3_re", ram_re, 0);
        chk("if_c3_addr", ram_addr, 32'h10);
        chk("if_c3_mem_ready", mem_ready, 0);
        cyc(); if_req = 1'b0; #1;
        chk("if_c4_ready", if_ready, 0);
        chk("if_c4_re", ram_re, 0);

        // ---------------- simultaneous IF + MEM load ----------------
        cyc(); if_req = 1'b1; if_addr = 32'h30; mem_r_en = 1'b1; mem_addr = 32'h80;
        ram_rdata = 32'h55; #1;
        chk("sim_c0_mem_stall", mem_stall, 1);
        chk("sim_c0_if_stall", if_stall, 1);
        cyc(); #1;
        chk("sim_c1_re", ram_re, 1);
        chk("sim_c1_addr", ram_addr, 32'h80);
        cyc(); #1;
        chk("sim_c2_mem_ready", mem_ready, 0);
        cyc(); #1;
        chk("sim_c3_mem_ready", mem_ready, 1);
        chk("sim_c3_mem_rdata", mem_rdata, 32'h55);
        chk("sim_c3_if_ready", if_ready, 0);
        chk("sim_c3_if_stall", if_stall, 1);
        chk("sim_c3_mem_stall", mem_stall, 0);
        cyc(); mem_r_en = 1'b0; ram_rdata = 32'hCAFEF00D; #1;
        chk("sim_c4_re", ram_re, 0);
        chk("sim_c4_mem_ready", mem_ready, 0);
        cyc(); #1;
        chk("sim_c5_re", ram_re, 1);
        chk("sim_c5_addr", ram_addr, 32'h30);
        cyc(); #1;
        chk("sim_c6_if_ready", if_ready, 0);
        cyc(); #1;
        chk("sim_c7_if_ready", if_ready, 1);
        chk("sim_c7_if_rdata", if_rdata, 32'hCAFEF00D);
        chk("sim_c7_mem_rdata", mem_rdata, 32'h55);
        cyc(); if_req = 1'b0; #1;
        chk("sim_c8_if_ready", if_ready, 0);

        // ---------------- store ----------------
        cyc(); mem_w_en = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h12345678;
        ram_rdata = 32'hFFFFFFFF; #1;
        chk("st_c0_we", ram_we, 0);
        for (int c = 1; c <= 2; c++) begin
            cyc(); #1;
            chk("st_acc_we", ram_we, 1);
            chk("st_acc_re", ram_re, 0);
            chk("st_acc_wdata", ram_wdata, 32'h12345678);
            chk("st_acc_addr", ram_addr, 32'h40);
            chk("st_acc_ready", mem_ready, 0);
        end
        cyc(); #1;
        chk("st_c3_we", ram_we, 0);
        chk("st_c3_ready", mem_ready, 1);
        chk("st_c3_mem_rdata", mem_rdata, 32'h55);
        cyc(); mem_w_en = 1'b0; #1;
        chk("st_c4_ready", mem_ready, 0);
        chk("st_c4_mem_rdata", mem_rdata, 32'h55);

        // ---------------- reset during store access ----------------
        cyc(); mem_w_en = 1'b1; mem_addr = 32'h44; mem_wdata = 32'hA5A5A5A5; #1;
        cyc(); #1;
        chk("rs_c1_we", ram_we, 1);
        rst = 1'b0; mem_w_en = 1'b0;
        cyc(); rst = 1'b1; #1;
        chk("rs_c2_we", ram_we, 0);
        chk("rs_c2_ready", mem_ready, 0);
        chk("rs_c2_addr", ram_addr, 0);
        chk("rs_c2_mem_rdata", mem_rdata, 0);
        for (int c = 3; c <= 5; c++) begin
            cyc(); #1;
            chk("rs_idle_we", ram_we, 0);
            chk("rs_idle_ready", mem_ready, 0);
        end

        // ---------------- latency 1 and 15 ----------------
        cyc(); if_req = 1'b1; if_addr = 32'h100; ram_rdata = 32'h0BADF00D; #1;
        chk("lat1_c0_ready", a_if_ready, 0);
        chk("lat15_c0_ready", b_if_ready, 0);
        for (int c = 1; c <= 16; c++) begin
            cyc(); #1;
            if (c <= 2) chk("lat1_ready", a_if_ready, (c == 2) ? 1 : 0);
            if (c == 1) chk("lat1_re", a_ram_re, 1);
            if (c == 2) chk("lat1_rdata", a_if_rdata, 32'h0BADF00D);
            chk("lat15_ready", b_if_ready, (c == 16) ? 1 : 0);
            if (c <= 15) chk("lat15_re", b_ram_re, 1);
        end
        chk("lat15_rdata", b_if_rdata, 32'h0BADF00D);
        chk("lat15_stall", b_if_stall, 0);
        cyc(); if_req = 1'b0; #1;
        chk("lat15_after_ready", b_if_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
